// File: rtl/addr_seq.sv
// Burst address sequencer: issues count addresses base, base+stride, ... (mod 2^ADDR_W)
// to a downstream decoder, with stall support and a one-cycle done pulse.
module addr_seq #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [ADDR_W:0]   count,
  input  logic              stall,
  output logic [ADDR_W-1:0] A,
  output logic              A_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic                a_valid_q, a_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   next_q, next_d;
  logic [ADDR_W-1:0]   stride_q, stride_d;
  logic [ADDR_W:0]     rem_q, rem_d;

  localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] REM_ZERO = {(ADDR_W+1){1'b0}};

  // Next-state and datapath; RUN with nothing left waits one cycle before DONE so
  // A_valid only ever appears while busy is high.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    a_valid_d = 1'b0;
    next_d    = next_q;
    stride_d  = stride_q;
    rem_d     = rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != REM_ZERO) begin
            next_d   = base;
            stride_d = stride;
            rem_d    = count;
            state_d  = RUN;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (rem_q == REM_ZERO) begin
          state_d = DONE;
        end else if (!stall) begin
          a_d       = next_q;
          a_valid_d = 1'b1;
          next_d    = next_q + stride_q;
          rem_d     = rem_q - REM_ONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= {ADDR_W{1'b0}};
      a_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      next_q    <= {ADDR_W{1'b0}};
      stride_q  <= {ADDR_W{1'b0}};
      rem_q     <= REM_ZERO;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      next_q    <= next_d;
      stride_q  <= stride_d;
      rem_q     <= rem_d;
    end
  end

  assign A       = a_q;
  assign A_valid = a_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_addr_seq.sv
// Scoreboard bench for addr_seq: directed bursts push expected addresses/done
// events into a queue; a negedge monitor pops and compares on A_valid or done.
module tb_addr_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] base;
  logic [4:0] stride;
  logic [5:0] count;
  logic       stall;
  logic [4:0] A;
  logic       A_valid;
  logic       busy;
  logic       done;

  typedef struct {
    bit is_done;
    int addr;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   acc_cyc;

  addr_seq #(.ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .stride(stride),
    .count(count), .stall(stall), .A(A), .A_valid(A_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_a(input int a);
    exp_t e;
    e.is_done = 1'b0; e.addr = a; e.lat = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int lat);
    exp_t e;
    e.is_done = 1'b1; e.addr = 0; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input int b, input int s, input int c);
    base   = 5'(b);
    stride = 5'(s);
    count  = 6'(c);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    acc_cyc = cyc;
  endtask

  // Monitor: every presented address or done pulse must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (A_valid || done)) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        if (A_valid) begin
          check("entry_is_addr", int'(e.is_done), 0);
          check("addr", int'(A), e.addr);
          check("busy_with_valid", int'(busy), 1);
          check("no_done_with_valid", int'(done), 0);
        end else begin
          check("entry_is_done", int'(e.is_done), 1);
          check("done_latency", cyc - acc_cyc, e.lat);
          check("busy_in_done", int'(busy), 0);
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; acc_cyc = 0;
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    base = 5'd0; stride = 5'd0; count = 6'd0;
    tick(2);
    check("rst_A", int'(A), 0);
    check("rst_A_valid", int'(A_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0;
    tick(1);

    // Full sweep 0..31, done 33 cycles after acceptance
    for (int i = 0; i < 32; i++) push_a(i);
    push_done(33);
    issue(0, 1, 32);
    check("first_cycle_busy", int'(busy), 1);
    check("first_cycle_no_valid", int'(A_valid), 0);
    tick(35);
    check("sweep_idle_busy", int'(busy), 0);

    // Wrapping stride
    push_a(30); push_a(1); push_a(4); push_a(7);
    push_done(5);
    issue(30, 3, 4);
    tick(7);

    // Stall for two cycles after the second address
    push_a(5); push_a(6); push_a(7); push_a(8);
    push_done(7);
    issue(5, 1, 4);
    tick(2);
    stall = 1'b1;
    tick(1);
    check("stall1_valid", int'(A_valid), 0);
    check("stall1_hold_A", int'(A), 6);
    check("stall1_busy", int'(busy), 1);
    tick(1);
    check("stall2_valid", int'(A_valid), 0);
    check("stall2_hold_A", int'(A), 6);
    stall = 1'b0;
    tick(6);

    // count = 0: straight to DONE, no address
    push_done(0);
    issue(9, 2, 0);
    check("cnt0_busy", int'(busy), 0);
    check("cnt0_A_hold", int'(A), 8);
    tick(3);
    check("cnt0_idle_done", int'(done), 0);

    // start ignored during RUN and during DONE
    push_a(10); push_a(11); push_a(12);
    push_done(4);
    issue(10, 1, 3);
    tick(1);
    base = 5'd20; stride = 5'd2; count = 6'd5; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    check("in_done_state", int'(done), 1);
    base = 5'd25; count = 6'd2; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    check("no_second_burst_busy", int'(busy), 0);

    // Reset after third address of a count=10 burst
    push_a(2); push_a(3); push_a(4);
    issue(2, 1, 10);
    tick(3);
    @(negedge clk);
    #1;
    reset = 1'b1; start = 1'b1; stall = 1'b1;
    #1;
    check("abort_A", int'(A), 0);
    check("abort_A_valid", int'(A_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    tick(2);
    check("rst_hold_busy", int'(busy), 0);
    check("rst_hold_done", int'(done), 0);
    reset = 1'b0; start = 1'b0; stall = 1'b0;
    tick(1);
    push_a(7);
    push_done(2);
    issue(7, 0, 1);
    tick(4);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/addr_seq.md
ADDR_SEQ -- requirements
Module: addr_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning address width feeding the downstream 5-to-32 decoder.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new address burst; sampled only in IDLE.
REQ-005 SHALL have port base  input  ADDR_W  first address of the burst; latched on accepted start.
REQ-006 SHALL have port stride  input  ADDR_W  address increment; latched on accepted start.
REQ-007 SHALL have port count  input  ADDR_W+1  number of addresses to issue, 0..32; latched on accepted start.
REQ-008 SHALL have port stall  input  1  downstream hold request; while high, no address advances.
REQ-009 SHALL have port A  output  ADDR_W  registered address to the decoder.
REQ-010 SHALL have port A_valid  output  1  A carries a new address this cycle.
REQ-011 SHALL have port busy  output  1  high in RUN state.
REQ-012 SHALL have port done  output  1  one-cycle pulse at end of burst.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-014 IDLE: start=1 with count>0 SHALL latch base/stride/count and go to RUN next cycle; start=1 with count=0 SHALL go directly to DONE with no A_valid.
REQ-015 start SHALL be ignored in RUN and DONE; latched parameters SHALL not change mid-burst.
REQ-016 RUN: first non-stalled cycle SHALL drive A=base, A_valid=1; each subsequent non-stalled cycle SHALL drive A=(previous A + stride) mod 2^ADDR_W, A_valid=1.
REQ-017 Address arithmetic SHALL be ADDR_W bits, carry discarded (wrap 31+1 -> 0); stride=0 SHALL repeat base count times.
REQ-018 A remaining counter (ADDR_W+1 bits) SHALL decrement once per issued address; when the last address is issued (counter 1 -> 0) the FSM SHALL go to DONE next cycle.
REQ-019 stall=1 in RUN SHALL force A_valid=0, hold A at its last value, and freeze the remaining counter and next-address register; issuing resumes exactly where it stopped when stall drops.
REQ-020 stall SHALL have no effect in IDLE or DONE.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start in that cycle SHALL be ignored.
REQ-022 busy SHALL be 1 iff state is RUN; done SHALL be 1 iff state is DONE.
REQ-023 A, A_valid, busy, done SHALL all be registered outputs (no combinational path from inputs).
REQ-024 Latency: start accepted at edge N -> first A_valid at edge N+1 (visible during cycle N+1 to N+2) absent stall; a burst of count addresses with no stall SHALL complete with done high count+1 cycles after acceptance.
REQ-025 A SHALL hold its last value in IDLE and DONE; A_valid SHALL be 0 outside RUN.

Reset
REQ-026 reset=1 SHALL asynchronously force state=IDLE, A=0, A_valid=0, busy=0, done=0, remaining counter=0, latched base/stride=0.
REQ-027 reset asserted mid-burst SHALL abort the burst with no done pulse; after release the block SHALL accept a new start normally.
REQ-028 Outputs SHALL remain at reset values while reset is high regardless of start or stall.

Verification
REQ-029 base=0, stride=1, count=32, no stall -> A=0,1,...,31 on 32 consecutive cycles with A_valid=1, then done pulse; downstream decoder Z equals 1<<A each cycle.
REQ-030 base=30, stride=3, count=4 -> A=30,1,4,7 (wrap), then done.
REQ-031 base=5, stride=1, count=4, stall high for 2 cycles after second address -> A=5,6,(hold 6, A_valid=0 x2),7,8, done; total 4 valid cycles.
REQ-032 count=0 start -> no A_valid, done pulse on next cycle, return to IDLE.
REQ-033 start pulsed again during RUN and during DONE -> ignored; burst sequence unchanged and no second burst.
REQ-034 reset asserted after third address of count=10 burst -> all outputs 0 immediately, no done; new start base=7,count=1 afterwards -> A=7 once, done.
